// File: rtl/pattern_scan_pkg.sv
// Shared types, default sizes and width helper for the pattern scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONFIGURED = 2'd1,
        SCAN       = 2'd2,
        DONE       = 2'd3
    } scan_state_t;

    typedef enum logic {
        WAIT  = 1'b0,
        MATCH = 1'b1
    } match_state_t;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    // Width needed to hold a pattern length from 0 up to pat_w inclusive.
    function automatic int len_w_f(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Moore serial pattern detector: shift register, bits-seen counter, masked compare.
// Latency: match_evt is combinational on the completing bit; hit is high the cycle after it.
// Backpressure: none; a bit is consumed on every cycle with en high.
module pattern_match_core
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = len_w_f(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit,
    output logic             match_evt
);

    logic [PAT_W-1:0] shift_q;
    logic [PAT_W-1:0] shift_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] bits_q;
    logic [LEN_W-1:0] bits_nxt;
    match_state_t     mstate_q;
    match_state_t     mstate_d;

    // Candidate shift/count after taking bit_in, compare mask, and the Moore next state.
    always_comb begin
        mask      = '0;
        shift_nxt = {shift_q[PAT_W-2:0], bit_in};
        bits_nxt  = (bits_q >= len) ? bits_q : bits_q + 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        match_evt = en && (len != '0) && (bits_nxt == len) &&
                    (((shift_nxt ^ pattern) & mask) == '0);
        mstate_d  = WAIT;
        if (!clr && match_evt) begin
            mstate_d = MATCH;
        end
    end

    assign hit = (mstate_q == MATCH);

    // Shift register and bits-seen history; non-overlapping mode restarts the count after a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            bits_q   <= '0;
            mstate_q <= WAIT;
        end else begin
            mstate_q <= mstate_d;
            if (clr) begin
                shift_q <= '0;
                bits_q  <= '0;
            end else if (en) begin
                shift_q <= shift_nxt;
                bits_q  <= (match_evt && !overlap) ? '0 : bits_nxt;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Configures, arms and sequences a serial pattern scan over a fixed or unlimited window.
// Latency: config/start take effect next cycle; hit/done appear the cycle after the bit.
// Backpressure: cfg_ready low outside IDLE/CONFIGURED; PSC_HIT_LOG_EN adds first_hit_pos.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int LEN_W = len_w_f(PAT_W)  // derived; leave at default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             cfg_overlap,
    output logic             cfg_err,
    input  logic             start,
    input  logic             abort,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             hit,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic [WIN_W-1:0] first_hit_pos
);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [WIN_W-1:0] win_q;
    logic             ovl_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [WIN_W-1:0] win_cnt_nxt;
    logic             cfg_acc;
    logic             scan_start;
    logic             bit_acc;
    logic             win_done;
    logic             match_evt;

    assign cfg_ready   = (state_q == IDLE) || (state_q == CONFIGURED);
    assign cfg_acc     = cfg_valid && cfg_ready;
    // A config offered together with start wins; start is dropped.
    assign scan_start  = (state_q == CONFIGURED) && start && !cfg_acc && !err_q;
    // Abort discards the bit sampled on the same edge.
    assign bit_acc     = (state_q == SCAN) && in_valid && !abort;
    assign win_cnt_nxt = win_cnt_q + 1'b1;
    assign win_done    = bit_acc && (win_q != '0) && (win_cnt_nxt == win_q);

    assign busy        = (state_q == SCAN);
    assign done        = (state_q == DONE);
    assign cfg_err     = err_q;
    assign match_count = cnt_q;

    // Controller next state; abort has priority over window completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (cfg_acc) state_d = CONFIGURED;
            CONFIGURED: if (scan_start) state_d = SCAN;
            SCAN: begin
                if (abort)         state_d = CONFIGURED;
                else if (win_done) state_d = DONE;
            end
            DONE:       state_d = CONFIGURED;
            default:    state_d = IDLE;
        endcase
    end

    // State, configuration registers and scan counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            win_q     <= '0;
            ovl_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_acc) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                win_q <= cfg_window;
                ovl_q <= cfg_overlap;
                err_q <= (cfg_len == '0) || (int'(cfg_len) > PAT_W);
            end
            if (scan_start) begin
                cnt_q     <= '0;
                win_cnt_q <= '0;
            end else begin
                if (match_evt && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
                if (bit_acc) win_cnt_q <= win_cnt_nxt;
            end
        end
    end

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clr       (scan_start),
        .en        (bit_acc),
        .bit_in    (in),
        .pattern   (pat_q),
        .len       (len_q),
        .overlap   (ovl_q),
        .hit       (hit),
        .match_evt (match_evt)
    );

`ifdef PSC_HIT_LOG_EN
    logic [WIN_W-1:0] first_hit_q;

    // Capture the 1-based index of the completing bit of the first hit in this scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_hit_q <= '0;
        end else if (scan_start) begin
            first_hit_q <= '0;
        end else if (match_evt && (cnt_q == '0)) begin
            first_hit_q <= win_cnt_nxt;
        end
    end

    assign first_hit_pos = first_hit_q;
`else
    assign first_hit_pos = '0;
`endif

endmodule
